add_round_key_stage: RTL and testbench
======================================

ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, last round index; only AES-128, i.e. 10, is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 key_load  input  1  one-cycle strobe; captures key_in as cipher key.
REQ-005 key_in  input  128  cipher key, byte 0 in [127:120].
REQ-006 in_valid  input  1  state_in valid.
REQ-007 in_ready  output  1  stage can accept state_in.
REQ-008 state_in  input  128  AES state, same byte order as key_in.
REQ-009 out_valid  output  1  state_out valid, for the SubBytes stage.
REQ-010 out_ready  input  1  downstream accepts state_out.
REQ-011 state_out  output  128  registered state_in XOR current round key.
REQ-012 round_out  output  4  round index (0..10) of the key applied to state_out.
REQ-013 last_out  output  1  high with out_valid when round_out equals NUM_ROUNDS.

Function
REQ-014 The stage SHALL drive in_ready = (!out_valid || out_ready) && !key_load.
REQ-015 An input transfer (in_valid && in_ready) SHALL register state_in XOR rk[r], round_out = r, and out_valid = 1 on the next edge; latency is 1 cycle.
REQ-016 An output transfer (out_valid && out_ready) without a simultaneous input transfer SHALL clear out_valid.
REQ-017 Simultaneous input and output transfers SHALL replace state_out with no bubble cycle.
REQ-018 While out_valid && !out_ready, state_out, round_out and last_out SHALL hold stable.
REQ-019 Round counter r SHALL advance by 1 on each input transfer. After r = NUM_ROUNDS it SHALL wrap to 0, and the round key SHALL reload from the stored cipher key.
REQ-020 rk[r+1] SHALL be derived on the fly from rk[r]:
- RotWord, then SubWord (4 S-box lookups), then XOR with Rcon[r+1], using Rcon = 01,02,04,08,10,20,40,80,1b,36;
- XOR chaining across words w0..w3;
- registered on each input transfer.
REQ-021 key_load SHALL:
- store key_in as the cipher key and as rk[0];
- set r = 0;
- clear out_valid on the next edge.
REQ-022 key_load SHALL take priority over a concurrent in_valid; no transfer occurs in that cycle.
REQ-023 Input before any key_load SHALL use the all-zero key.

Reset
REQ-024 On rst, the following SHALL clear to 0 on the next edge: out_valid, state_out, round_out, last_out, r, round key and stored cipher key.
REQ-025 rst SHALL have priority over key_load and in_valid.
REQ-026 rst mid-operation SHALL discard any pending output.

Configuration
REQ-027 With AES_RKEY_OUT_EN defined, the stage SHALL add an output rkey_out[127:0] carrying the round key registered alongside state_out, reset to 0.
REQ-028 Without AES_RKEY_OUT_EN, the rkey_out port and its register SHALL be absent, and function SHALL otherwise be identical.

Structure
REQ-029 A shared package SHALL hold:
- the Rcon table;
- AES_STATE_W = 128;
- AES_ROUND_W = 4;
- AES128_ROUNDS = 10.
REQ-030 SubWord SHALL use four instances of the existing Sbox module, instantiated inside one sub-module named key_sched_step that computes rk[r+1] from rk[r] and r.

Verification
REQ-031 key_load 2b7e151628aed2a6abf7158809cf4f3c, then state_in 3243f6a8885a308d313198a2e0370734 -> state_out 193de3bea0f4e22b9ac68d2ae9f84808, round_out 0, 1 cycle later.
REQ-032 Same key, 11 back-to-back zero states with out_ready = 1:
- output 2 SHALL be a0fafe1788542cb123a339392a6c7605;
- output 11 SHALL be d014f9a8c9ee2589e13f0cc8b6630ca6 with last_out = 1;
- in_ready SHALL stay high throughout.
REQ-033 out_ready held low for 5 cycles with in_valid high -> in_ready low, state_out stable; one transfer completes on release; no data lost or duplicated.
REQ-034 12th zero state after REQ-032 -> round_out 0, state_out 2b7e151628aed2a6abf7158809cf4f3c.
REQ-035 key_load asserted with in_valid at round 5 -> no transfer; out_valid low next cycle; next input uses round 0 of the new key.
REQ-036 rst pulsed while out_valid = 1 and out_ready = 0 -> all outputs 0 next cycle; next input XORs the zero key.

Source files
------------

// File: rtl/add_round_key_stage_pkg.sv
// add_round_key_stage_pkg
// Shared constants and helpers for the AES-128 AddRoundKey stage and its
// on-the-fly key schedule.
//   AES_STATE_W   : width of an AES state / round key (128)
//   AES_ROUND_W   : width of a round index (4)
//   AES128_ROUNDS : last round index for AES-128 (10)
//   RCON          : round constants, entry n is used to derive rk[n+1]
//   rcon_for()    : bounded Rcon lookup, returns 0 outside the table
package add_round_key_stage_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_ROUND_W   = 4;
  localparam int AES128_ROUNDS = 10;

  localparam logic [7:0] RCON [AES128_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Deriving rk[r+1] from rk[r] uses RCON[r]. Round 10 never feeds the
  // schedule (the key reloads instead), so out-of-range rounds return 0.
  function automatic logic [7:0] rcon_for(input logic [AES_ROUND_W-1:0] round);
    rcon_for = 8'h00;
    if (round < AES_ROUND_W'(AES128_ROUNDS)) begin
      rcon_for = RCON[round];
    end
  endfunction

endpackage

// File: rtl/Sbox.sv
// Sbox
// AES forward substitution box, purely combinational.
//   in_byte  : input byte
//   out_byte : S-box(in_byte)
module Sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 sits in the top byte, so entry a lives at bit offset (255-a)*8,
  // and 255-a is simply the bitwise inverse of a.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/key_sched_step.sv
// key_sched_step
// One step of the AES-128 key expansion: computes rk[r+1] from rk[r].
//   rk_in  : current round key rk[r], word w0 in [127:96]
//   round  : current round index r (selects Rcon[r+1])
//   rk_out : next round key rk[r+1]
module key_sched_step
  import add_round_key_stage_pkg::*;
(
  input  logic [AES_STATE_W-1:0] rk_in,
  input  logic [AES_ROUND_W-1:0] round,
  output logic [AES_STATE_W-1:0] rk_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] temp_word;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = rk_in[127:96];
  assign w1 = rk_in[95:64];
  assign w2 = rk_in[63:32];
  assign w3 = rk_in[31:0];

  // RotWord moves the most significant byte of w3 to the bottom.
  assign rot_word = {w3[23:0], w3[31:24]};

  // SubWord: one S-box per byte of the rotated word.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    Sbox u_sbox (
      .in_byte  (rot_word[8*i +: 8]),
      .out_byte (sub_word[8*i +: 8])
    );
  end

  // Rcon only touches the most significant byte of the word.
  assign temp_word = sub_word ^ {rcon_for(round), 24'h000000};

  // Each new word chains off the previous new word.
  assign n0 = w0 ^ temp_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/add_round_key_stage.sv
// add_round_key_stage
// AES-128 AddRoundKey pipeline stage with an on-the-fly key schedule.
// Each accepted state is XORed with the current round key; the round
// counter then advances and the next round key is derived in place.
// After the last round the counter wraps and the key reloads from the
// stored cipher key.
//   clk, rst           : clock, synchronous active-high reset
//   key_load, key_in   : one-cycle strobe capturing a new cipher key
//   in_valid, in_ready : input handshake for state_in
//   state_in           : AES state, byte 0 in [127:120]
//   out_valid, out_ready : output handshake toward SubBytes
//   state_out          : state_in XOR round key, registered
//   round_out          : round index of the key applied to state_out
//   last_out           : high with out_valid on the final round
//   rkey_out           : round key applied to state_out (only when
//                        AES_RKEY_OUT_EN is defined)
// Only NUM_ROUNDS = 10 (AES-128) is supported.
module add_round_key_stage
  import add_round_key_stage_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_load,
  input  logic [AES_STATE_W-1:0] key_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic [AES_ROUND_W-1:0] round_out,
  output logic                   last_out
`ifdef AES_RKEY_OUT_EN
  ,
  output logic [AES_STATE_W-1:0] rkey_out
`endif
);

  localparam logic [AES_ROUND_W-1:0] LAST_ROUND = AES_ROUND_W'(NUM_ROUNDS);

  logic [AES_STATE_W-1:0] cipher_key;
  logic [AES_STATE_W-1:0] round_key;
  logic [AES_STATE_W-1:0] next_round_key;
  logic [AES_ROUND_W-1:0] round_cnt;
  logic                   in_xfer;
  logic                   out_xfer;

  // A new key blocks input for its cycle so a state is never combined with
  // a key that is about to be replaced.
  assign in_ready = (!out_valid || out_ready) && !key_load;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  key_sched_step u_key_sched_step (
    .rk_in  (round_key),
    .round  (round_cnt),
    .rk_out (next_round_key)
  );

  // Main datapath and key/round bookkeeping. Reset beats key_load, which
  // beats an input transfer (in_ready already excludes key_load cycles).
  // last_out is cleared together with out_valid so it is only ever seen
  // alongside valid data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      state_out  <= '0;
      round_out  <= '0;
      last_out   <= 1'b0;
      round_cnt  <= '0;
      round_key  <= '0;
      cipher_key <= '0;
    end else if (key_load) begin
      cipher_key <= key_in;
      round_key  <= key_in;
      round_cnt  <= '0;
      out_valid  <= 1'b0;
      last_out   <= 1'b0;
    end else if (in_xfer) begin
      state_out <= state_in ^ round_key;
      round_out <= round_cnt;
      last_out  <= (round_cnt == LAST_ROUND);
      out_valid <= 1'b1;
      if (round_cnt == LAST_ROUND) begin
        round_cnt <= '0;
        round_key <= cipher_key;
      end else begin
        round_cnt <= round_cnt + 1'b1;
        round_key <= next_round_key;
      end
    end else if (out_xfer) begin
      out_valid <= 1'b0;
      last_out  <= 1'b0;
    end
  end

`ifdef AES_RKEY_OUT_EN
  // Debug copy of the key that produced state_out, captured on the same
  // transfer so the two always belong together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rkey_out <= '0;
    end else if (!key_load && in_xfer) begin
      rkey_out <= round_key;
    end
  end
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   round_out;
  logic         last_out;
`ifdef AES_RKEY_OUT_EN
  logic [127:0] rkey_out;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PB   = 128'hffeeddccbbaa99887766554433221100;

  // FIPS-197 Appendix A round keys for KEY
  localparam logic [127:0] RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  typedef struct {
    logic [127:0] state_in;
    logic [127:0] exp_state;
    logic [3:0]   exp_round;
    logic         exp_last;
  } vec_t;

  vec_t vecs [12];

  add_round_key_stage #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .round_out (round_out),
    .last_out  (last_out)
`ifdef AES_RKEY_OUT_EN
    ,
    .rkey_out  (rkey_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [127:0] st,
                               input logic ordy, input logic kl,
                               input logic [127:0] k);
    in_valid  = iv;
    state_in  = st;
    out_ready = ordy;
    key_load  = kl;
    key_in    = k;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic loadKey(input logic [127:0] k);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, k);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 11; i++) begin
      vecs[i].state_in  = '0;
      vecs[i].exp_state = RK[i];
      vecs[i].exp_round = 4'(i);
      vecs[i].exp_last  = (i == 10);
    end
    vecs[11].state_in  = '0;
    vecs[11].exp_state = KEY;
    vecs[11].exp_round = 4'd0;
    vecs[11].exp_last  = 1'b0;

    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_state_out", state_out, 128'd0);
    checkOutput("rst_round_out", 128'(round_out), 128'd0);
    checkOutput("rst_last_out", 128'(last_out), 128'd0);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);

    $display("[TB] input before any key uses zero key");
    applyStimulus(1'b1, PA, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("nokey_state", state_out, PA);
    checkOutput("nokey_round", 128'(round_out), 128'd0);
    checkOutput("nokey_valid", 128'(out_valid), 128'd1);

    $display("[TB] FIPS-197 round 0");
    loadKey(KEY);
    checkOutput("keyload_clears_valid", 128'(out_valid), 128'd0);
    applyStimulus(1'b1, 128'h3243f6a8885a308d313198a2e0370734, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("fips_state", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    checkOutput("fips_round", 128'(round_out), 128'd0);
    checkOutput("fips_valid", 128'(out_valid), 128'd1);
`ifdef AES_RKEY_OUT_EN
    checkOutput("fips_rkey", rkey_out, KEY);
`endif
    tick();
    checkOutput("drain_valid", 128'(out_valid), 128'd0);

    $display("[TB] 12 back-to-back zero states");
    loadKey(KEY);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].state_in, 1'b1, 1'b0, '0);
      #1;
      checkOutput($sformatf("b2b_in_ready_%0d", i), 128'(in_ready), 128'd1);
      tick();
      checkOutput($sformatf("b2b_state_%0d", i), state_out, vecs[i].exp_state);
      checkOutput($sformatf("b2b_round_%0d", i), 128'(round_out), 128'(vecs[i].exp_round));
      checkOutput($sformatf("b2b_last_%0d", i), 128'(last_out), 128'(vecs[i].exp_last));
      checkOutput($sformatf("b2b_valid_%0d", i), 128'(out_valid), 128'd1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    checkOutput("b2b_drain_valid", 128'(out_valid), 128'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, PA, 1'b0, 1'b0, '0);
    tick();
    checkOutput("bp_first_state", state_out, PA ^ RK[1]);
    checkOutput("bp_first_round", 128'(round_out), 128'd1);
    applyStimulus(1'b1, PB, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
      tick();
      checkOutput($sformatf("bp_hold_state_%0d", i), state_out, PA ^ RK[1]);
      checkOutput($sformatf("bp_hold_round_%0d", i), 128'(round_out), 128'd1);
      checkOutput($sformatf("bp_hold_valid_%0d", i), 128'(out_valid), 128'd1);
    end
    applyStimulus(1'b1, PB, 1'b1, 1'b0, '0);
    #1;
    checkOutput("bp_release_ready", 128'(in_ready), 128'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("bp_second_state", state_out, PB ^ RK[2]);
    checkOutput("bp_second_round", 128'(round_out), 128'd2);
    checkOutput("bp_second_valid", 128'(out_valid), 128'd1);
    tick();
    checkOutput("bp_no_dup", 128'(out_valid), 128'd0);

    $display("[TB] key_load with in_valid at round 5");
    loadKey(KEY);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, '0, 1'b1, 1'b0, '0);
      tick();
      checkOutput($sformatf("r5_state_%0d", i), state_out, RK[i]);
    end
    applyStimulus(1'b1, '0, 1'b1, 1'b1, KEY2);
    #1;
    checkOutput("kl_in_ready", 128'(in_ready), 128'd0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("kl_valid_low", 128'(out_valid), 128'd0);
    applyStimulus(1'b1, '0, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("kl_new_state", state_out, KEY2);
    checkOutput("kl_new_round", 128'(round_out), 128'd0);

    $display("[TB] reset while stalled");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst2_valid", 128'(out_valid), 128'd0);
    checkOutput("rst2_state", state_out, 128'd0);
    checkOutput("rst2_round", 128'(round_out), 128'd0);
    checkOutput("rst2_last", 128'(last_out), 128'd0);
`ifdef AES_RKEY_OUT_EN
    checkOutput("rst2_rkey", rkey_out, 128'd0);
`endif
    applyStimulus(1'b1, PB, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("rst2_zero_key_state", state_out, PB);
    checkOutput("rst2_zero_key_round", 128'(round_out), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
